// File: rtl/mod_reducer.sv
// Restoring shift-subtract reducer: produces X mod N and X / N, one quotient bit per clock.
// Optional MODRED_EARLY_EXIT_EN finishes in one cycle when X < N.
module mod_reducer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load,
  input  logic [15:0] X,
  input  logic [15:0] N,
  output logic [15:0] R,
  output logic [15:0] Q,
  output logic        Done,
  output logic        Busy,
  output logic        Err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] x_q, x_d;
  logic [15:0] n_q, n_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] r_q, r_d;
  logic [15:0] q_q, q_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  // The shifted remainder needs a 17th bit so moduli above 16'h8000 cannot overflow.
  logic [16:0] rem_sh;
  logic [15:0] rem_sub;
  logic [15:0] rem_nxt;
  logic [15:0] x_nxt;
  logic        ge;
  logic        early;

  assign rem_sh  = {rem_q, x_q[15]};
  assign ge      = (rem_sh >= {1'b0, n_q});
  assign rem_sub = rem_sh[15:0] - n_q;
  assign rem_nxt = ge ? rem_sub : rem_sh[15:0];
  assign x_nxt   = {x_q[14:0], ge};

`ifdef MODRED_EARLY_EXIT_EN
  assign early = (cnt_q == 4'd0) && (x_q < n_q);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    n_d     = n_q;
    rem_d   = rem_q;
    r_d     = r_q;
    q_d     = q_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (Load) begin
          x_d     = X;
          n_d     = N;
          rem_d   = 16'd0;
          cnt_d   = 4'd0;
          r_d     = 16'd0;
          q_d     = 16'd0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (n_q == 16'd0) begin
          r_d     = x_q;
          q_d     = 16'hFFFF;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (early) begin
          r_d     = x_q;
          q_d     = 16'd0;
          state_d = S_DONE;
        end else begin
          rem_d = rem_nxt;
          x_d   = x_nxt;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            r_d     = rem_nxt;
            q_d     = x_nxt;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      x_q     <= 16'd0;
      n_q     <= 16'd0;
      rem_q   <= 16'd0;
      r_q     <= 16'd0;
      q_q     <= 16'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      r_q     <= r_d;
      q_q     <= q_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign R    = r_q;
  assign Q    = q_q;
  assign Done = done_q;
  assign Busy = busy_q;
  assign Err  = err_q;

endmodule

// File: tb/tb_mod_reducer.sv
// Bench for mod_reducer: arithmetic reference model compared every cycle, plus directed literal checks.
module tb_mod_reducer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Load = 1'b0;
  logic [15:0] X = 16'd0;
  logic [15:0] N = 16'd0;
  logic [15:0] R, Q;
  logic        Done, Busy, Err;

  int checks = 0;
  int errors = 0;
  int tick = 0;

  mod_reducer dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .X(X), .N(N),
    .R(R), .Q(Q), .Done(Done), .Busy(Busy), .Err(Err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) tick <= tick + 1;

  // Reference model: timeline of idle / busy for a given number of edges / one done cycle.
  int          m_phase;  // 0 idle, 1 busy, 2 done
  int          m_left;
  logic [15:0] m_r, m_q, p_r, p_q;
  logic        m_err, p_err, m_done, m_busy;

  function automatic int latency(input logic [15:0] x, input logic [15:0] n);
    if (n == 16'd0) return 1;
`ifdef MODRED_EARLY_EXIT_EN
    if (x < n) return 1;
`endif
    return 16;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_phase <= 0; m_left <= 0;
      m_r <= 16'd0; m_q <= 16'd0; m_err <= 1'b0;
      m_done <= 1'b0; m_busy <= 1'b0;
    end else begin
      case (m_phase)
        0: if (Load) begin
          m_phase <= 1; m_busy <= 1'b1;
          m_left  <= latency(X, N);
          m_r <= 16'd0; m_q <= 16'd0; m_err <= 1'b0;
          if (N == 16'd0) begin
            p_r <= X; p_q <= 16'hFFFF; p_err <= 1'b1;
          end else begin
            p_r <= X % N; p_q <= X / N; p_err <= 1'b0;
          end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase <= 2; m_busy <= 1'b0; m_done <= 1'b1;
            m_r <= p_r; m_q <= p_q; m_err <= p_err;
          end
        end
        default: begin
          m_phase <= 0; m_done <= 1'b0;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp_v);
    end
  endtask

  always @(negedge Clk) begin
    chk("model_done", {15'd0, Done}, {15'd0, m_done});
    chk("model_busy", {15'd0, Busy}, {15'd0, m_busy});
    chk("model_err",  {15'd0, Err},  {15'd0, m_err});
    chk("model_r", R, m_r);
    chk("model_q", Q, m_q);
  end

  // Called at a negedge while the DUT is idle; returns at a negedge back in IDLE.
  task automatic run_op(input logic [15:0] x, input logic [15:0] n,
                        input logic [15:0] er, input logic [15:0] eq,
                        input logic ee, input int elat);
    int cyc;
    X = x; N = n; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    cyc = 0;
    while (!Done && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
    chk("lit_latency", cyc[15:0], elat[15:0]);
    chk("lit_r", R, er);
    chk("lit_q", Q, eq);
    chk("lit_err", {15'd0, Err}, {15'd0, ee});
    @(negedge Clk);
    chk("lit_done_pulse", {15'd0, Done}, 16'd0);
  endtask

  task automatic wait_done(output int at);
    int n_wait;
    n_wait = 0;
    @(negedge Clk);
    while (!Done && n_wait < 100) begin
      @(negedge Clk);
      n_wait++;
    end
    checks++;
    if (!Done) begin
      errors++;
      $display("FAIL wait_done: Done=%b, required 1 within 100 cycles", Done);
    end
    at = tick;
  endtask

  initial begin
    int d1, d2;
    int early_lat;
`ifdef MODRED_EARLY_EXIT_EN
    early_lat = 1;
`else
    early_lat = 16;
`endif
    repeat (2) @(negedge Clk);
    chk("rst_r", R, 16'd0);
    chk("rst_q", Q, 16'd0);
    chk("rst_flags", {13'd0, Done, Busy, Err}, 16'd0);
    Reset = 1'b0;
    @(negedge Clk);

    run_op(16'd200,   16'd7,     16'd4,      16'd28, 1'b0, 16);
    run_op(16'd729,   16'd33,    16'd3,      16'd22, 1'b0, 16);
    run_op(16'hFFFF,  16'hFFFF,  16'd0,      16'd1,  1'b0, 16);
    run_op(16'hFFFF,  16'h8001,  16'h7FFE,   16'd1,  1'b0, 16);
    run_op(16'd5,     16'd9,     16'd5,      16'd0,  1'b0, early_lat);
    run_op(16'd100,   16'd0,     16'd100,    16'hFFFF, 1'b1, 1);
    run_op(16'd100,   16'd10,    16'd0,      16'd10, 1'b0, 16);
    run_op(16'd12345, 16'd1,     16'd0,      16'd12345, 1'b0, 16);

    // Load held high; inputs change mid-run and must not disturb the in-flight result.
    X = 16'd200; N = 16'd7; Load = 1'b1;
    repeat (5) @(negedge Clk);
    X = 16'd729; N = 16'd33;
    wait_done(d1);
    chk("b2b_first_r", R, 16'd4);
    chk("b2b_first_q", Q, 16'd28);
    wait_done(d2);
    Load = 1'b0;
    chk("b2b_second_r", R, 16'd3);
    chk("b2b_second_q", Q, 16'd22);
    chk("b2b_spacing", 16'(d2 - d1), 16'd18);
    repeat (2) @(negedge Clk);

    // Asynchronous abort part-way through the iterations.
    X = 16'd200; N = 16'd7; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    repeat (8) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("abort_r", R, 16'd0);
    chk("abort_q", Q, 16'd0);
    chk("abort_flags", {13'd0, Done, Busy, Err}, 16'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (20) begin
      @(negedge Clk);
      chk("abort_no_done", {15'd0, Done}, 16'd0);
    end
    run_op(16'd200, 16'd7, 16'd4, 16'd28, 1'b0, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
